// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port between execution pipes.
// Optional performance counters are enabled with `define WB_ARB_PERF_CNT_EN.
module writeback_arbiter #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_WIDTH  = 5,
    localparam int unsigned PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int unsigned CNT_W     = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS*REG_WIDTH-1:0]  req_rd,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_PORTS-1:0]            req_register_write,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic                            wb_valid,
    output logic [REG_WIDTH-1:0]            wb_rd,
    output logic [DATA_WIDTH-1:0]           wb_data,
    output logic                            wb_register_write,
    output logic [PTR_W-1:0]                wb_port
`ifdef WB_ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]                conflict_cycles,
    output logic [NUM_PORTS*CNT_W-1:0]      stall_cycles
`endif
);

    logic [PTR_W-1:0]      rr_ptr;
    logic [NUM_PORTS-1:0]  grant;
    logic                  found;
    logic [PTR_W-1:0]      sel_idx;
    logic [REG_WIDTH-1:0]  sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_wr;
    int unsigned           pos;

    logic [REG_WIDTH-1:0]  rd_arr   [NUM_PORTS];
    logic [DATA_WIDTH-1:0] data_arr [NUM_PORTS];

    // Unpack flat per-port payload buses.
    always_comb begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            rd_arr[i]   = req_rd[i*REG_WIDTH +: REG_WIDTH];
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        sel_idx  = '0;
        sel_rd   = '0;
        sel_data = '0;
        sel_wr   = 1'b0;
        pos      = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            pos = 32'(rr_ptr) + k;
            if (pos >= NUM_PORTS) begin
                pos = pos - NUM_PORTS;
            end
            if (!found && req_valid[PTR_W'(pos)]) begin
                found                = 1'b1;
                grant[PTR_W'(pos)]   = 1'b1;
                sel_idx              = PTR_W'(pos);
                sel_rd               = rd_arr[PTR_W'(pos)];
                sel_data             = data_arr[PTR_W'(pos)];
                sel_wr               = req_register_write[PTR_W'(pos)];
            end
        end
    end

    // No acceptance while reset is held; pending requests are re-presented afterwards.
    assign req_ready = rst ? '0 : grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= (32'(sel_idx) == NUM_PORTS - 1) ? '0 : sel_idx + PTR_W'(1);
        end
    end

    // Writeback bundle; payload fields hold across idle cycles, x0 writes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid          <= 1'b0;
            wb_rd             <= '0;
            wb_data           <= '0;
            wb_register_write <= 1'b0;
            wb_port           <= '0;
        end else begin
            wb_valid          <= found;
            wb_register_write <= found && sel_wr && (|sel_rd);
            if (found) begin
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
                wb_port <= sel_idx;
            end
        end
    end

`ifdef WB_ARB_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt [NUM_PORTS];

    // Saturating counters: contention cycles and per-port stalled-request cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cycles <= '0;
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                stall_cnt[i] <= '0;
            end
        end else begin
            if (($countones(req_valid) >= 2) && (conflict_cycles != '1)) begin
                conflict_cycles <= conflict_cycles + CNT_W'(1);
            end
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                if (req_valid[i] && !grant[i] && (stall_cnt[i] != '1)) begin
                    stall_cnt[i] <= stall_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            stall_cycles[i*CNT_W +: CNT_W] = stall_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed testbench for writeback_arbiter (default build, 4 ports, 32-bit data, 5-bit rd).
module tb_writeback_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [19:0]  req_rd;
    logic [127:0] req_data;
    logic [3:0]   req_register_write;
    logic [3:0]   req_ready;
    logic         wb_valid;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic         wb_register_write;
    logic [1:0]   wb_port;
`ifdef WB_ARB_PERF_CNT_EN
    logic [31:0]  conflict_cycles;
    logic [127:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    writeback_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_rd             (req_rd),
        .req_data           (req_data),
        .req_register_write (req_register_write),
        .req_ready          (req_ready),
        .wb_valid           (wb_valid),
        .wb_rd              (wb_rd),
        .wb_data            (wb_data),
        .wb_register_write  (wb_register_write),
        .wb_port            (wb_port)
`ifdef WB_ARB_PERF_CNT_EN
        ,
        .conflict_cycles    (conflict_cycles),
        .stall_cycles       (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [4:0] rd,
                         input logic [31:0] d, input logic w);
        req_valid[i]             = v;
        req_rd[i*5 +: 5]         = rd;
        req_data[i*32 +: 32]     = d;
        req_register_write[i]    = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'b0000; req_rd = '0; req_data = '0; req_register_write = '0;
        rst = 1'b1;
        drive(2, 1'b1, 5'd9, 32'h1234_5678, 1'b1);
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b0000);
        end
        step();
        step();
        total++;
        if ({wb_valid, wb_rd, wb_data, wb_register_write, wb_port} !== 40'h0) begin
            bad++;
            $display("FAIL reset_bundle got v=%b rd=%0d d=%h w=%b p=%0d exp all zero",
                     wb_valid, wb_rd, wb_data, wb_register_write, wb_port);
        end
        req_valid = 4'b0000;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        drive(1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL single_ready got=%b exp=%b", req_ready, 4'b0010);
        end
        step();
        req_valid = 4'b0000;
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEAD_BEEF ||
            wb_register_write !== 1'b1 || wb_port !== 2'd1) begin
            bad++;
            $display("FAIL single_bundle got v=%b rd=%0d d=%h w=%b p=%0d exp v=1 rd=5 d=deadbeef w=1 p=1",
                     wb_valid, wb_rd, wb_data, wb_register_write, wb_port);
        end
    endtask

    task automatic test_all_valid();
        int accepts [4];
        for (int i = 0; i < 4; i++) accepts[i] = 0;
        do_reset();
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b1);
        for (int c = 0; c < 8; c++) begin
            logic [3:0] exp_rdy;
            exp_rdy = 4'b0001 << (c % 4);
            #1;
            total++;
            if (req_ready !== exp_rdy) begin
                bad++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_rdy);
            end
            for (int i = 0; i < 4; i++) if (req_ready[i]) accepts[i]++;
            step();
            total++;
            if (wb_valid !== 1'b1 || wb_port !== 2'(c % 4) || wb_rd !== 5'(10 + c % 4) ||
                wb_data !== 32'h100 + 32'(c % 4)) begin
                bad++;
                $display("FAIL rr_bundle cyc=%0d got v=%b p=%0d rd=%0d d=%h exp v=1 p=%0d",
                         c, wb_valid, wb_port, wb_rd, wb_data, c % 4);
            end
        end
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (accepts[i] !== 2) begin
                bad++; $display("FAIL rr_accepts port=%0d got=%0d exp=2", i, accepts[i]);
            end
        end
    endtask

    // rr_ptr is 0 on entry; port 2 alone must be granted immediately.
    task automatic test_x0_write();
        drive(2, 1'b1, 5'd0, 32'hCAFE_0000, 1'b1);
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL x0_ready got=%b exp=%b", req_ready, 4'b0100);
        end
        step();
        req_valid = 4'b0000;
        total++;
        if (wb_valid !== 1'b1 || wb_register_write !== 1'b0 || wb_port !== 2'd2 ||
            wb_data !== 32'hCAFE_0000) begin
            bad++;
            $display("FAIL x0_bundle got v=%b w=%b p=%0d d=%h exp v=1 w=0 p=2 d=cafe0000",
                     wb_valid, wb_register_write, wb_port, wb_data);
        end
    endtask

    // rr_ptr is 3 on entry; port 3 (a store, wr=0) wins over port 0, then wrap to 0.
    task automatic test_wrap();
        drive(0, 1'b1, 5'd3, 32'hAAAA_0000, 1'b1);
        drive(3, 1'b1, 5'd7, 32'hBBBB_3333, 1'b0);
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++; $display("FAIL wrap_ready1 got=%b exp=%b", req_ready, 4'b1000);
        end
        step();
        req_valid[3] = 1'b0;
        total++;
        if (wb_valid !== 1'b1 || wb_port !== 2'd3 || wb_rd !== 5'd7 || wb_register_write !== 1'b0) begin
            bad++;
            $display("FAIL wrap_bundle1 got v=%b p=%0d rd=%0d w=%b exp v=1 p=3 rd=7 w=0",
                     wb_valid, wb_port, wb_rd, wb_register_write);
        end
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL wrap_ready2 got=%b exp=%b", req_ready, 4'b0001);
        end
        step();
        req_valid = 4'b0000;
        total++;
        if (wb_valid !== 1'b1 || wb_port !== 2'd0 || wb_data !== 32'hAAAA_0000 ||
            wb_register_write !== 1'b1) begin
            bad++;
            $display("FAIL wrap_bundle2 got v=%b p=%0d d=%h w=%b exp v=1 p=0 d=aaaa0000 w=1",
                     wb_valid, wb_port, wb_data, wb_register_write);
        end
    endtask

    task automatic test_idle_hold();
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL idle_ready got=%b exp=%b", req_ready, 4'b0000);
        end
        step();
        total++;
        if (wb_valid !== 1'b0 || wb_register_write !== 1'b0 || wb_port !== 2'd0 ||
            wb_rd !== 5'd3 || wb_data !== 32'hAAAA_0000) begin
            bad++;
            $display("FAIL idle_hold got v=%b w=%b p=%0d rd=%0d d=%h exp v=0 w=0 p=0 rd=3 d=aaaa0000",
                     wb_valid, wb_register_write, wb_port, wb_rd, wb_data);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 1'b1, 5'd1, 32'h1111_1111, 1'b1);
        step();                          // grant to port 1 moves rr_ptr to 2
        req_valid = 4'b0000;
        drive(0, 1'b1, 5'd4, 32'h0000_0A0A, 1'b1);
        drive(2, 1'b1, 5'd6, 32'h0000_0C0C, 1'b1);
        rst = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL rstmid_ready got=%b exp=%b", req_ready, 4'b0000);
        end
        step();
        rst = 1'b0;
        total++;
        if (wb_valid !== 1'b0 || wb_data !== 32'h0 || wb_port !== 2'd0) begin
            bad++;
            $display("FAIL rstmid_bundle got v=%b d=%h p=%0d exp v=0 d=0 p=0", wb_valid, wb_data, wb_port);
        end
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL rstmid_first got=%b exp=%b", req_ready, 4'b0001);
        end
        step();
        total++;
        if (wb_valid !== 1'b1 || wb_port !== 2'd0 || wb_rd !== 5'd4) begin
            bad++;
            $display("FAIL rstmid_after got v=%b p=%0d rd=%0d exp v=1 p=0 rd=4", wb_valid, wb_port, wb_rd);
        end
        req_valid[0] = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL rstmid_next got=%b exp=%b", req_ready, 4'b0100);
        end
        step();
        req_valid = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_x0_write();
        test_wrap();
        test_idle_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
